// File: rtl/cam_pkg.sv
// Shared camera-path definitions: pattern encodings, source FSM states, RGB565
// colour-bar constants and the QCIF frame dimensions used by capture and VGA.
package cam_pkg;

  localparam int QCIF_H_ACTIVE = 176;
  localparam int QCIF_V_ACTIVE = 144;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_SOLID    = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Left-to-right order of the eight colour bars.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates and the latched
// pattern selection to an RGB565 colour.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int          H_ACTIVE     = QCIF_H_ACTIVE,
  parameter int          XW           = 8,
  parameter int          YW           = 8,
  parameter logic [15:0] SOLID_RGB565 = RGB_RED
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  pattern_e      pattern,
  output logic [15:0]   rgb
);

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic [XW-1:0] bar_full;
  logic [2:0]    bar_idx;
  logic [7:0]    x8;
  logic [7:0]    y8;
  rgb565_t       gradient;

  // Any remainder pixels when H_ACTIVE is not a multiple of 8 extend the last bar.
  assign bar_full = x / XW'(BAR_W);
  assign bar_idx  = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];

  assign x8 = 8'(x);
  assign y8 = 8'(y);

  always_comb begin
    gradient   = '0;
    gradient.r = x8[7:3];
    gradient.g = x8[7:2];
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    rgb = RGB_BLACK;
    case (pattern)
      PAT_BARS:     rgb = bar_color(bar_idx);
      PAT_SOLID:    rgb = SOLID_RGB565;
      PAT_GRADIENT: rgb = gradient;
      PAT_CHECKER:  rgb = (((x8 ^ y8) & 8'h08) != 8'h00) ? RGB_WHITE : RGB_BLACK;
      default:      rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/cam_pixel_source.sv
// OV7670-style parallel camera emulator (PCLK/VSYNC/HREF/D[7:0], RGB565 bytes).
// Define CAM_SRC_NEG_SYNC_EN to drive VSYNC and HREF active-low.
module cam_pixel_source
  import cam_pkg::*;
#(
  parameter int          H_ACTIVE     = QCIF_H_ACTIVE,
  parameter int          V_ACTIVE     = QCIF_V_ACTIVE,
  parameter int          H_BLANK      = 48,
  parameter int          VSYNC_LINES  = 3,
  parameter int          VBP_LINES    = 17,
  parameter int          VFP_LINES    = 10,
  parameter int          CLK_DIV      = 2,
  parameter logic [15:0] SOLID_RGB565 = 16'hF800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int HW         = $clog2(LINE_PCLKS);
  localparam int MAX_LINES  = max_of4(VSYNC_LINES, VBP_LINES, V_ACTIVE, VFP_LINES);
  localparam int LW         = $clog2(MAX_LINES + 1);
  localparam int DW         = $clog2(CLK_DIV);

`ifdef CAM_SRC_NEG_SYNC_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  // PCLK divider -------------------------------------------------------------
  logic          running;
  logic [DW-1:0] div_cnt;
  logic          tick;

  // The tick is the clk edge at which cam_pclk falls.
  assign tick = running && (div_cnt == DW'(CLK_DIV / 2 - 1));

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values and simulation matches hardware.
    if (reset) begin
      running  <= 1'b0;
      div_cnt  <= '0;
      cam_pclk <= 1'b0;
    end else if (!running) begin
      running  <= 1'b1;
      div_cnt  <= '0;
      cam_pclk <= 1'b1;
    end else if (div_cnt == DW'(CLK_DIV - 1)) begin
      div_cnt  <= '0;
      cam_pclk <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (tick) cam_pclk <= 1'b0;
    end
  end

  // Frame timing FSM ---------------------------------------------------------
  cam_state_e    state, state_next;
  logic [HW-1:0] h_cnt, h_next;
  logic [LW-1:0] line_cnt, line_next;
  pattern_e      pattern_q, pattern_next;
  logic          done_next;
  logic          end_of_line;
  logic          last_line;
  int            lines_in_state;

  always_comb begin
    state_next     = state;
    h_next         = h_cnt;
    line_next      = line_cnt;
    pattern_next   = pattern_q;
    done_next      = 1'b0;
    lines_in_state = 1;

    case (state)
      ST_VSYNC:  lines_in_state = VSYNC_LINES;
      ST_VBP:    lines_in_state = VBP_LINES;
      ST_ACTIVE: lines_in_state = V_ACTIVE;
      ST_VFP:    lines_in_state = VFP_LINES;
      default:   lines_in_state = 1;
    endcase

    end_of_line = (h_cnt == HW'(LINE_PCLKS - 1));
    last_line   = end_of_line && (line_cnt == LW'(lines_in_state - 1));

    // Counters describe the PCLK period that starts at this tick; IDLE parks them at 0.
    if (state != ST_IDLE) begin
      h_next = end_of_line ? '0 : h_cnt + 1'b1;
      if (end_of_line) line_next = last_line ? '0 : line_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next   = ST_VSYNC;
          pattern_next = pattern_e'(pattern_sel);
        end
      end
      ST_VSYNC:  if (last_line) state_next = ST_VBP;
      ST_VBP:    if (last_line) state_next = ST_ACTIVE;
      ST_ACTIVE: if (last_line) state_next = ST_VFP;
      ST_VFP: begin
        if (last_line) begin
          done_next = 1'b1;
          if (enable) begin
            state_next   = ST_VSYNC;
            pattern_next = pattern_e'(pattern_sel);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pixel content and next-period outputs -------------------------------------
  logic [15:0] pixel;
  logic        vsync_next;
  logic        href_next;
  logic [7:0]  data_next;

  cam_pattern_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .XW           (HW - 1),
    .YW           (LW),
    .SOLID_RGB565 (SOLID_RGB565)
  ) u_pattern_gen (
    .x       (h_next[HW-1:1]),
    .y       (line_next),
    .pattern (pattern_next),
    .rgb     (pixel)
  );

  assign vsync_next = (state_next == ST_VSYNC);
  assign href_next  = (state_next == ST_ACTIVE) && (h_next < HW'(2 * H_ACTIVE));
  // Even byte carries {R, G[5:3]}, odd byte {G[2:0], B}.
  assign data_next  = !href_next ? 8'h00 : (h_next[0] ? pixel[7:0] : pixel[15:8]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      h_cnt       <= '0;
      line_cnt    <= '0;
      pattern_q   <= PAT_BARS;
      cam_vsync   <= SYNC_IDLE;
      cam_href    <= SYNC_IDLE;
      cam_data    <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        state      <= state_next;
        h_cnt      <= h_next;
        line_cnt   <= line_next;
        pattern_q  <= pattern_next;
        cam_vsync  <= SYNC_IDLE ^ vsync_next;
        cam_href   <= SYNC_IDLE ^ href_next;
        cam_data   <= data_next;
        frame_done <= done_next;
        if (done_next) frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_source.sv
// Self-checking bench for cam_pixel_source on a reduced frame geometry; every
// sampled PCLK period is compared with a frame model built from the timing rules.
module tb_cam_pixel_source;

  localparam int HA    = 64;
  localparam int VA    = 16;
  localparam int HB    = 16;
  localparam int VS    = 3;
  localparam int VBP   = 2;
  localparam int VFP   = 2;
  localparam int CD    = 2;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = (VS + VBP + VA + VFP) * LINE;
  localparam int ACT0  = VS + VBP;
  localparam int MAX_FAIL = 25;

`ifdef CAM_SRC_NEG_SYNC_EN
  localparam logic NEG = 1'b1;
`else
  localparam logic NEG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_done;
  logic [15:0] frame_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_count = 16'h0000;
  int          cur_pat = 0;
  logic [7:0]  line_buf [2*HA];
  logic [15:0] cap_pix  [VA][HA];

  always #5 clk = ~clk;

  cam_pixel_source #(
    .H_ACTIVE     (HA),
    .V_ACTIVE     (VA),
    .H_BLANK      (HB),
    .VSYNC_LINES  (VS),
    .VBP_LINES    (VBP),
    .VFP_LINES    (VFP),
    .CLK_DIV      (CD),
    .SOLID_RGB565 (16'hF800)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  // Reference pixel colour straight from the pattern definitions.
  function automatic logic [15:0] ref_pixel(input int pat, input int x, input int y);
    case (pat)
      0: begin
        case (x / (HA / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return 16'hF800;
      2: return 16'((((x >> 3) & 31) << 11) | (((x >> 2) & 63) << 5));
      default: return ((((x >> 3) ^ (y >> 3)) & 1) == 1) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Current sample must be PCLK period 0 of a frame (just after the VSYNC-entry tick).
  task automatic check_frame(input int pat, input logic mid_en, input logic next_en,
                             input int next_pat, input bit scramble);
    int          line;
    int          h;
    int          runs;
    logic        e_vs;
    logic        e_hr;
    logic        o_vs;
    logic        o_hr;
    logic        prev_hr;
    logic [7:0]  e_d;
    logic [15:0] px;
    runs    = 0;
    prev_hr = 1'b0;
    for (int p = 0; p < FRAME; p++) begin
      line = p / LINE;
      h    = p % LINE;
      e_vs = (line < VS);
      e_hr = (line >= ACT0) && (line < ACT0 + VA) && (h < 2 * HA);
      e_d  = 8'h00;
      if (e_hr) begin
        px  = ref_pixel(pat, h / 2, line - ACT0);
        e_d = (h % 2 == 1) ? px[7:0] : px[15:8];
      end
      o_vs = cam_vsync ^ NEG;
      o_hr = cam_href ^ NEG;
      n_tests++;
      if (cam_pclk !== 1'b0 || o_vs !== e_vs || o_hr !== e_hr || cam_data !== e_d) begin
        n_fail++;
        $display("FAIL frame_sample pat=%0d p=%0d: got pclk=%b vsync=%b href=%b data=%h, need pclk=0 vsync=%b href=%b data=%h",
                 pat, p, cam_pclk, o_vs, o_hr, cam_data, e_vs, e_hr, e_d);
      end
      if (p > 0) begin
        n_tests++;
        if (frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_done_early p=%0d: got %b, need 0", p, frame_done);
        end
      end
      if (o_hr === 1'b1 && prev_hr !== 1'b1) runs++;
      prev_hr = o_hr;
      if (e_hr) begin
        if (line == ACT0) line_buf[h] = cam_data;
        if (h % 2 == 0) cap_pix[line - ACT0][h / 2][15:8] = cam_data;
        else            cap_pix[line - ACT0][h / 2][7:0]  = cam_data;
      end
      if (scramble && p == FRAME / 3) pattern_sel = 2'($urandom);
      if (p == (ACT0 + 5) * LINE + 7) enable = mid_en;
      if (p == FRAME - LINE) begin
        enable      = next_en;
        pattern_sel = 2'(next_pat);
      end
      step();
      n_tests++;
      if (cam_pclk !== 1'b1 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL pclk_high_phase p=%0d: got pclk=%b frame_done=%b, need pclk=1 frame_done=0",
                 p, cam_pclk, frame_done);
      end
      step();
      if (n_fail > MAX_FAIL) finish_run();
    end
    exp_count = exp_count + 16'd1;
    n_tests++;
    if (frame_done !== 1'b1 || frame_count !== exp_count) begin
      n_fail++;
      $display("FAIL frame_end: got frame_done=%b frame_count=%0d, need frame_done=1 frame_count=%0d",
               frame_done, frame_count, exp_count);
    end
    n_tests++;
    if (runs != VA) begin
      n_fail++;
      $display("FAIL href_runs: got %0d, need %0d", runs, VA);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (5) step();
    n_tests++;
    if ({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_count} !==
        {1'b0, NEG, NEG, 8'h00, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got pclk=%b vs=%b hr=%b d=%h fd=%b fc=%0d, need pclk=0 vs=%b hr=%b d=00 fd=0 fc=0",
               cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_count, NEG, NEG);
    end
  endtask

  // Release reset with enable high and check the first PCLK phase and VSYNC entry.
  task automatic release_and_start(input string tag);
    reset = 1'b0;
    step();
    n_tests++;
    if (cam_pclk !== 1'b1 || cam_vsync !== NEG) begin
      n_fail++;
      $display("FAIL %s_first_clk: got pclk=%b vsync=%b, need pclk=1 vsync=%b", tag, cam_pclk, cam_vsync, NEG);
    end
    step();
    n_tests++;
    if (cam_pclk !== 1'b0 || cam_vsync !== ~NEG) begin
      n_fail++;
      $display("FAIL %s_vsync_entry: got pclk=%b vsync=%b, need pclk=0 vsync=%b", tag, cam_pclk, cam_vsync, ~NEG);
    end
  endtask

  task automatic test_color_bars();
    enable = 1'b1;
    pattern_sel = 2'd0;
    release_and_start("start");
    check_frame(0, 1'b1, 1'b1, 3, 1'b0);
    cur_pat = 3;
    n_tests++;
    if ({line_buf[0], line_buf[1], line_buf[16], line_buf[17], line_buf[2*HA-2], line_buf[2*HA-1]} !==
        48'hFFFF_FFE0_0000) begin
      n_fail++;
      $display("FAIL bar_bytes: got %h %h %h %h %h %h, need FF FF FF E0 00 00",
               line_buf[0], line_buf[1], line_buf[16], line_buf[17], line_buf[2*HA-2], line_buf[2*HA-1]);
    end
  endtask

  task automatic test_checkerboard();
    int nxt;
    nxt = int'($urandom_range(3, 0));
    check_frame(3, 1'b1, 1'b1, nxt, 1'b1);
    cur_pat = nxt;
    n_tests++;
    if (cap_pix[0][8] !== 16'hFFFF || cap_pix[8][8] !== 16'h0000 || cap_pix[8][0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL checker_pixels: got (8,0)=%h (8,8)=%h (0,8)=%h, need FFFF 0000 FFFF",
               cap_pix[0][8], cap_pix[8][8], cap_pix[8][0]);
    end
  endtask

  task automatic test_random_patterns();
    check_frame(cur_pat, 1'b1, 1'b1, 1, 1'b1);
    cur_pat = 1;
  endtask

  task automatic test_solid();
    check_frame(1, 1'b1, 1'b1, 2, 1'b1);
    cur_pat = 2;
    n_tests++;
    if (cap_pix[5][17] !== 16'hF800) begin
      n_fail++;
      $display("FAIL solid_pixel: got %h, need F800", cap_pix[5][17]);
    end
  endtask

  task automatic test_enable_drop();
    check_frame(2, 1'b0, 1'b0, int'($urandom_range(3, 0)), 1'b1);
    n_tests++;
    if (cap_pix[0][8] !== 16'h0840 || cap_pix[3][HA-1] !== 16'h39E0) begin
      n_fail++;
      $display("FAIL gradient_pixels: got x8=%h x63=%h, need 0840 39E0", cap_pix[0][8], cap_pix[3][HA-1]);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      step();
      n_tests++;
      if (cam_pclk !== ((i % 2 == 0) ? 1'b1 : 1'b0) || cam_vsync !== NEG || cam_href !== NEG ||
          cam_data !== 8'h00 || frame_done !== 1'b0 || frame_count !== exp_count) begin
        n_fail++;
        $display("FAIL idle_outputs i=%0d: got pclk=%b vs=%b hr=%b d=%h fd=%b fc=%0d, need pclk=%b vs=%b hr=%b d=00 fd=0 fc=%0d",
                 i, cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_count,
                 (i % 2 == 0), NEG, NEG, exp_count);
      end
    end
  endtask

  task automatic test_restart_from_idle();
    bit found;
    int waited;
    cur_pat     = int'($urandom_range(3, 0));
    pattern_sel = 2'(cur_pat);
    enable      = 1'b1;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      waited++;
      if ((cam_vsync ^ NEG) === 1'b1) found = 1'b1;
    end
    n_tests++;
    if (!found || waited != 2) begin
      n_fail++;
      $display("FAIL restart_latency: got found=%b after %0d clks, need found=1 after 2", found, waited);
      if (!found) finish_run();
    end
    check_frame(cur_pat, 1'b1, 1'b1, cur_pat, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    repeat (2 * ((ACT0 + 10) * LINE + 5)) step();
    reset = 1'b1;
    step();
    exp_count = 16'h0000;
    n_tests++;
    if ({cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_count} !==
        {1'b0, NEG, NEG, 8'h00, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL mid_reset_state: got pclk=%b vs=%b hr=%b d=%h fd=%b fc=%0d, need pclk=0 vs=%b hr=%b d=00 fd=0 fc=0",
               cam_pclk, cam_vsync, cam_href, cam_data, frame_done, frame_count, NEG, NEG);
    end
    repeat (2) step();
    n_tests++;
    if (frame_done !== 1'b0 || frame_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got fd=%b fc=%0d, need fd=0 fc=0", frame_done, frame_count);
    end
    release_and_start("restart");
    check_frame(cur_pat, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_color_bars();
    test_checkerboard();
    test_random_patterns();
    test_solid();
    test_enable_drop();
    test_idle();
    test_restart_from_idle();
    test_reset_mid_frame();
    finish_run();
  end

endmodule
